// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states and access kind.
package mem_responder_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned BYTE_OFFSET = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_access_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-clock storage with registered, write-first read port.
module mem_responder_ram #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter              TAG        = "ram"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;
  logic             unused_tag_c;

  assign unused_tag_c = ^TAG;
  assign rdata_o      = rdata_q;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register; a same-edge write to the same word is forwarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with open-page fast path and back-to-back accepts.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned PAGE_WIDTH   = 7,
  parameter int unsigned LATENCY      = 3,
  parameter int unsigned PAGE_LATENCY = 1,
  parameter              TAG          = "mem"
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] dataIn,
  input  logic                  re,
  input  logic                  we,
  output logic [WORD_WIDTH-1:0] dataOut,
  output logic                  ready,
  output logic                  pageHit,
  output logic                  conflict
);

  localparam int unsigned PN_W  = ADDR_WIDTH - PAGE_WIDTH;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  mem_access_e           kind_q;
  logic                  hit_q;
  logic [PN_W-1:0]       open_pg_q;
  logic                  open_vld_q;
  logic                  conflict_q;
  logic                  ready_q, ready_d;
  logic                  page_hit_q, page_hit_d;

  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] word_c;
  logic [PN_W-1:0]       page_c;
  logic                  hit_c;
  logic [CNT_W-1:0]      lat_c;
  logic                  ram_re_c;
  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_raddr_c;
  logic                  unused_addr_c;

  assign word_c        = addr[ADDR_WIDTH+BYTE_OFFSET-1:BYTE_OFFSET];
  assign page_c        = word_c[ADDR_WIDTH-1:PAGE_WIDTH];
  assign unused_addr_c = ^{addr[WORD_WIDTH-1:ADDR_WIDTH+BYTE_OFFSET], addr[BYTE_OFFSET-1:0]};
  assign accept_c      = ((state_q == S_IDLE) || (state_q == S_DONE)) && (re || we);
  assign hit_c         = open_vld_q && (page_c == open_pg_q);
  assign lat_c         = hit_c ? CNT_W'(PAGE_LATENCY - 1) : CNT_W'(LATENCY - 1);

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept from IDLE/DONE, count down in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          state_d = (lat_c == '0) ? S_DONE : S_WAIT;
          cnt_d   = lat_c;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and storage controls for the transfer about to complete.
  always_comb begin
    ready_d     = (state_d == S_DONE);
    page_hit_d  = 1'b0;
    ram_re_c    = 1'b0;
    ram_raddr_c = waddr_q;
    ram_we_c    = res && (state_q == S_DONE) && (kind_q == MEM_WRITE);
    if (state_d == S_DONE) begin
      if (accept_c) begin
        page_hit_d  = hit_c;
        ram_re_c    = !we;
        ram_raddr_c = word_c;
      end else begin
        page_hit_d = hit_q;
        ram_re_c   = (kind_q == MEM_READ);
      end
    end
  end

  // Request latches, open-page tracking and registered status outputs.
  always_ff @(posedge clk) begin
    if (!res) begin
      waddr_q    <= '0;
      wdata_q    <= '0;
      kind_q     <= MEM_READ;
      hit_q      <= 1'b0;
      open_pg_q  <= '0;
      open_vld_q <= 1'b0;
      conflict_q <= 1'b0;
      ready_q    <= 1'b0;
      page_hit_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      page_hit_q <= page_hit_d;
      if (accept_c) begin
        waddr_q    <= word_c;
        wdata_q    <= dataIn;
        kind_q     <= we ? MEM_WRITE : MEM_READ;
        hit_q      <= hit_c;
        open_pg_q  <= page_c;
        open_vld_q <= 1'b1;
        if (re && we) begin
          conflict_q <= 1'b1;
        end
      end
    end
  end

  mem_responder_ram #(
    .WIDTH     (WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TAG       ({TAG, "/Store"})
  ) u_store (
    .clk    (clk),
    .rst_n  (res),
    .re_i   (ram_re_c),
    .raddr_i(ram_raddr_c),
    .rdata_o(dataOut),
    .we_i   (ram_we_c),
    .waddr_i(waddr_q),
    .wdata_i(wdata_q)
  );

  assign ready    = ready_q;
  assign pageHit  = page_hit_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters.
module tb_mem_responder;

  logic        clk;
  logic        res;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic        re;
  logic        we;
  logic [31:0] dataOut;
  logic        ready;
  logic        pageHit;
  logic        conflict;

  int          n_checks;
  int          n_err;
  int          lat;
  logic [31:0] data;
  logic        hit;

  mem_responder dut (
    .clk     (clk),
    .res     (res),
    .addr    (addr),
    .dataIn  (dataIn),
    .re      (re),
    .we      (we),
    .dataOut (dataOut),
    .ready   (ready),
    .pageHit (pageHit),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    re = 1'b0;
    we = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request, wait (bounded) for ready; returns in the ready cycle.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int l, output logic [31:0] q, output logic h);
    re     = r;
    we     = w;
    addr   = a;
    dataIn = d;
    @(posedge clk);
    #1;
    re     = 1'b0;
    we     = 1'b0;
    addr   = 'x;
    dataIn = 'x;
    l = 1;
    while (ready !== 1'b1 && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    q = dataOut;
    h = pageHit;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    res      = 1'b0;
    re       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    dataIn   = '0;
    idle(3);
    res = 1'b1;
    idle(1);

    // Preload storage through the bus.
    xfer(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, lat, data, hit);
    xfer(1'b0, 1'b1, 32'h0000_0020, 32'hC0FF_EE00, lat, data, hit);
    xfer(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, lat, data, hit);
    xfer(1'b0, 1'b1, 32'h0000_01FC, 32'h01FC_01FC, lat, data, hit);
    xfer(1'b0, 1'b1, 32'h0000_0200, 32'h0200_0200, lat, data, hit);
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 1'b1, 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), lat, data, hit);
    end
    idle(2);

    // Reset state.
    res = 1'b0;
    idle(2);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pagehit", 32'(pageHit), 32'd0);
    chk("rst_dataout", dataOut, 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    res = 1'b1;
    idle(1);

    // Read miss: accept at edge 0, ready observed at edge 3 only.
    re   = 1'b1;
    addr = 32'h0000_0100;
    @(posedge clk);
    #1;
    re   = 1'b0;
    addr = 'x;
    chk("miss_e1_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("miss_e2_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("miss_e3_ready", 32'(ready), 32'd1);
    chk("miss_e3_data", dataOut, 32'h1234_5678);
    chk("miss_e3_hit", 32'(pageHit), 32'd0);
    @(posedge clk);
    #1;
    chk("miss_e4_ready", 32'(ready), 32'd0);

    // Write then read of the same word on the ready cycle.
    xfer(1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, lat, data, hit);
    chk("wr_lat", 32'(lat), 32'd3);
    xfer(1'b1, 1'b0, 32'h0000_0200, 32'h0, lat, data, hit);
    chk("rd_after_wr_lat", 32'(lat), 32'd1);
    chk("rd_after_wr_data", data, 32'hDEAD_BEEF);
    chk("rd_after_wr_hit", 32'(hit), 32'd1);
    idle(2);

    // Burst of 16 reads within one page.
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, lat, data, hit);
      chk($sformatf("burst%0d_lat", i), 32'(lat), (i == 0) ? 32'd3 : 32'd1);
      chk($sformatf("burst%0d_data", i), data, 32'hA000_0000 + 32'(i));
      chk($sformatf("burst%0d_hit", i), 32'(hit), (i == 0) ? 32'd0 : 32'd1);
    end

    // Page crossing and address aliasing.
    xfer(1'b1, 1'b0, 32'h0000_01FC, 32'h0, lat, data, hit);
    chk("pg1fc_lat", 32'(lat), 32'd3);
    chk("pg1fc_data", data, 32'h01FC_01FC);
    chk("pg1fc_hit", 32'(hit), 32'd0);
    xfer(1'b1, 1'b0, 32'h0000_0200, 32'h0, lat, data, hit);
    chk("pg200_lat", 32'(lat), 32'd3);
    chk("pg200_data", data, 32'hDEAD_BEEF);
    chk("pg200_hit", 32'(hit), 32'd0);
    xfer(1'b1, 1'b0, 32'h0000_4000, 32'h0, lat, data, hit);
    chk("alias_lat", 32'(lat), 32'd3);
    chk("alias_data", data, 32'h0BAD_F00D);
    xfer(1'b1, 1'b0, 32'h0000_0000, 32'h0, lat, data, hit);
    chk("alias0_lat", 32'(lat), 32'd1);
    chk("alias0_data", data, 32'h0BAD_F00D);
    chk("alias0_hit", 32'(hit), 32'd1);
    idle(1);

    // Conflict: re and we together act as a write and latch the flag.
    chk("conflict_pre", 32'(conflict), 32'd0);
    xfer(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0055, lat, data, hit);
    chk("conflict_lat", 32'(lat), 32'd1);
    idle(3);
    chk("conflict_set", 32'(conflict), 32'd1);
    xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, data, hit);
    chk("conflict_rd_data", data, 32'h0000_0055);
    chk("conflict_sticky", 32'(conflict), 32'd1);
    idle(1);

    // Reset in the middle of a write wait.
    xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, lat, data, hit);
    chk("pre_rst_data", data, 32'hA000_0000);
    idle(1);
    we     = 1'b1;
    addr   = 32'h0000_0020;
    dataIn = 32'h1111_1111;
    @(posedge clk);
    #1;
    we     = 1'b0;
    addr   = 'x;
    res    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_e%0d_ready", i), 32'(ready), 32'd0);
    end
    chk("midrst_dataout", dataOut, 32'd0);
    chk("midrst_pagehit", 32'(pageHit), 32'd0);
    chk("midrst_conflict", 32'(conflict), 32'd0);
    res = 1'b1;
    idle(1);
    xfer(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, data, hit);
    chk("postrst_lat", 32'(lat), 32'd3);
    chk("postrst_data", data, 32'hC0FF_EE00);
    chk("postrst_hit", 32'(hit), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
